uart_tx_p: RTL and testbench

Memory-mapped UART transmitter peripheral on the memory controller's peripheral bus, alongside led_p, sw_p, push_button_p and vga_p. The CPU writes bytes into an 8-entry FIFO. A baud-rate engine serialises them as 8N1 frames on `txd`. A level interrupt signals "transmitter drained" so software can refill without polling.

---
 rtl/uart_tx_p.sv | 156 +++++++++++++++
 tb/tb_uart_tx_p.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_p.sv
// Memory-mapped 8N1 UART transmitter: byte FIFO, baud engine, drain interrupt.
// Registers: 0x0 TXDATA, 0x1 STATUS, 0x2 DIVISOR, 0x3 INTCTRL.
module uart_tx_p #(
   parameter int CLK_DIV    = 434,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wea,
   input  logic [3:0]  addra,
   input  logic [31:0] dina,
   output logic [31:0] douta,
   output logic        txd,
   output logic        int_tx_done
);

   localparam logic [1:0]  S_IDLE    = 2'd0;
   localparam logic [1:0]  S_START   = 2'd1;
   localparam logic [1:0]  S_DATA    = 2'd2;
   localparam logic [1:0]  S_STOP    = 2'd3;
   localparam logic [3:0]  DEPTH     = 4'(FIFO_DEPTH);
   localparam logic [2:0]  PTR_MASK  = 3'(FIFO_DEPTH - 1);
   localparam logic [15:0] DIV_RESET = 16'(CLK_DIV);

   logic [7:0]  mem [FIFO_DEPTH];
   logic [2:0]  wr_ptr;
   logic [2:0]  rd_ptr;
   logic [3:0]  count;
   logic [1:0]  state;
   logic [7:0]  shreg;
   logic [15:0] bitlen;
   logic [15:0] baud_cnt;
   logic [2:0]  bit_cnt;
   logic [15:0] divisor;
   logic        int_en;
   logic        ovf;

   logic        full;
   logic        empty;
   logic        busy;
   logic        wr_txdata;
   logic        push;
   logic        pop;
   logic        bit_end;
   logic        unused_dina;

   assign full        = (count == DEPTH);
   assign empty       = (count == 4'd0);
   assign busy        = (state != S_IDLE);
   assign wr_txdata   = wea && (addra == 4'h0);
   assign push        = wr_txdata && !full;
   assign bit_end     = (baud_cnt == 16'd0);
   // A pop also happens on the last stop cycle so frames run back to back.
   assign pop         = !empty && ((state == S_IDLE) || ((state == S_STOP) && bit_end));
   assign unused_dina = ^dina[31:16];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= dina[7:0];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= 3'd0;
         rd_ptr <= 3'd0;
         count  <= 4'd0;
      end else begin
         if (push) wr_ptr <= (wr_ptr + 3'd1) & PTR_MASK;
         if (pop)  rd_ptr <= (rd_ptr + 3'd1) & PTR_MASK;
         count <= count + {3'b000, push} - {3'b000, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= S_IDLE;
         shreg    <= 8'h00;
         bitlen   <= DIV_RESET;
         baud_cnt <= 16'd0;
         bit_cnt  <= 3'd0;
      end else if (pop) begin
         // Divisor is latched only here, so register writes never disturb a frame.
         shreg    <= mem[rd_ptr];
         bitlen   <= divisor;
         baud_cnt <= divisor - 16'd1;
         bit_cnt  <= 3'd0;
         state    <= S_START;
      end else begin
         case (state)
            S_START: begin
               if (bit_end) begin
                  baud_cnt <= bitlen - 16'd1;
                  state    <= S_DATA;
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  baud_cnt <= bitlen - 16'd1;
                  shreg    <= {1'b0, shreg[7:1]};
                  if (bit_cnt == 3'd7) state <= S_STOP;
                  else bit_cnt <= bit_cnt + 3'd1;
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end
            S_STOP: begin
               if (bit_end) state <= S_IDLE;
               else baud_cnt <= baud_cnt - 16'd1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         divisor <= DIV_RESET;
         int_en  <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         if (wea && (addra == 4'h2)) begin
            divisor <= (dina[15:0] < 16'd2) ? 16'd2 : dina[15:0];
         end
         if (wea && (addra == 4'h3)) int_en <= dina[0];
         if (wr_txdata && full) ovf <= 1'b1;
         else if (wea && (addra == 4'h1) && dina[7]) ovf <= 1'b0;
      end
   end

   // Read data reflects register state before any same-edge write or pop.
   always_ff @(posedge clk) begin
      if (!rst) begin
         douta       <= 32'h0;
         int_tx_done <= 1'b0;
      end else begin
         case (addra)
            4'h1:    douta <= {24'h0, ovf, busy, empty, full, count};
            4'h2:    douta <= {16'h0, divisor};
            4'h3:    douta <= {31'h0, int_en};
            default: douta <= 32'h0;
         endcase
         int_tx_done <= int_en && empty && !busy;
      end
   end

   always_comb begin
      txd = 1'b1;
      case (state)
         S_START: txd = 1'b0;
         S_DATA:  txd = shreg[0];
         default: txd = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_p.sv
// Directed bench for uart_tx_p: register map, framing, FIFO overflow,
// back-to-back timing, interrupt, divisor isolation and reset behaviour.
module tb_uart_tx_p;

   logic        clk = 1'b0;
   logic        rst;
   logic        wea;
   logic [3:0]  addra;
   logic [31:0] dina;
   logic [31:0] douta;
   logic        txd;
   logic        int_tx_done;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];

   uart_tx_p dut (
      .clk         (clk),
      .rst         (rst),
      .wea         (wea),
      .addra       (addra),
      .dina        (dina),
      .douta       (douta),
      .txd         (txd),
      .int_tx_done (int_tx_done)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
      wea = 1'b1; addra = a; dina = d;
      @(posedge clk); #1;
      wea = 1'b0; addra = 4'h0; dina = 32'h0;
   endtask

   task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
      addra = a;
      @(posedge clk); #1;
      d = douta;
      addra = 4'h0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   function automatic logic frame_bit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k >= 9) return 1'b1;
      return b[k-1];
   endfunction

   // Waits (bounded) for a start bit, then samples each bit near its middle.
   task automatic capture_frame(input int bitlen, output logic [7:0] b, output logic ok);
      ok = 1'b0;
      b  = 8'h00;
      for (int i = 0; i < 20000 && txd !== 1'b0; i++) begin
         @(posedge clk); #1;
      end
      if (txd !== 1'b0) return;
      idle_cycles(bitlen / 2);
      if (txd !== 1'b0) return;
      for (int k = 0; k < 8; k++) begin
         idle_cycles(bitlen);
         b[k] = txd;
      end
      idle_cycles(bitlen);
      if (txd !== 1'b1) return;
      ok = 1'b1;
   endtask

   task automatic test_reset;
      logic [31:0] rd;
      rst = 1'b0; wea = 1'b0; addra = 4'h0; dina = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd got %b exp 1", txd); end
      checks++;
      if (douta !== 32'h0) begin errors++; $display("FAIL reset_douta got %h exp 0", douta); end
      checks++;
      if (int_tx_done !== 1'b0) begin errors++; $display("FAIL reset_int got %b exp 0", int_tx_done); end
      rst = 1'b1;
      bus_read(4'h1, rd);
      checks++;
      if (rd !== 32'h20) begin errors++; $display("FAIL reset_status got %h exp 20", rd); end
      bus_read(4'h2, rd);
      checks++;
      if (rd !== 32'd434) begin errors++; $display("FAIL reset_divisor got %0d exp 434", rd); end
      bus_read(4'h3, rd);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL reset_intctrl got %h exp 0", rd); end
   endtask

   task automatic test_single_byte;
      logic [31:0] rd;
      logic        e;
      bus_write(4'h2, 32'd4);
      bus_write(4'h0, 32'h55);
      checks++;
      if (txd !== 1'b1) begin errors++; $display("FAIL single_pre_start got %b exp 1", txd); end
      for (int j = 0; j < 40; j++) begin
         @(posedge clk); #1;
         e = frame_bit(8'h55, j / 4);
         checks++;
         if (txd !== e) begin errors++; $display("FAIL single_seq cycle %0d got %b exp %b", j, txd, e); end
      end
      for (int j = 0; j < 8; j++) begin
         @(posedge clk); #1;
         checks++;
         if (txd !== 1'b1) begin errors++; $display("FAIL single_idle cycle %0d got %b exp 1", j, txd); end
      end
      bus_read(4'h1, rd);
      checks++;
      if (rd !== 32'h20) begin errors++; $display("FAIL single_status got %h exp 20", rd); end
   endtask

   task automatic test_fill_overflow;
      logic [31:0] rd;
      logic [7:0]  b;
      logic [7:0]  exp_b;
      logic        ok;
      bus_write(4'h2, 32'd1000);
      for (int i = 1; i <= 10; i++) begin
         bus_write(4'h0, 32'(i));
         if (i <= 9) exp_q.push_back(8'(i));
      end
      bus_read(4'h1, rd);
      checks++;
      if (rd !== 32'hD8) begin errors++; $display("FAIL fill_status got %h exp d8", rd); end
      // Remaining frames run at a short divisor; the frame in flight keeps 1000.
      bus_write(4'h2, 32'd4);
      for (int i = 0; i < 9; i++) begin
         capture_frame((i == 0) ? 1000 : 4, b, ok);
         exp_b = exp_q.pop_front();
         checks++;
         if (ok !== 1'b1 || b !== exp_b) begin
            errors++; $display("FAIL fill_frame %0d got %h ok %b exp %h", i, b, ok, exp_b);
         end
      end
      idle_cycles(6);
      bus_read(4'h1, rd);
      checks++;
      if (rd !== 32'hA0) begin errors++; $display("FAIL fill_ovf_sticky got %h exp a0", rd); end
      bus_write(4'h1, 32'h7F);
      bus_read(4'h1, rd);
      checks++;
      if (rd !== 32'hA0) begin errors++; $display("FAIL fill_ovf_noclear got %h exp a0", rd); end
      bus_write(4'h1, 32'h80);
      bus_read(4'h1, rd);
      checks++;
      if (rd !== 32'h20) begin errors++; $display("FAIL fill_ovf_clear got %h exp 20", rd); end
   endtask

   task automatic test_back_to_back;
      logic e;
      bus_write(4'h3, 32'h1);
      bus_write(4'h2, 32'd2);
      checks++;
      if (int_tx_done !== 1'b1) begin errors++; $display("FAIL b2b_int_idle got %b exp 1", int_tx_done); end
      bus_write(4'h0, 32'hA5);
      checks++;
      if (int_tx_done !== 1'b1) begin errors++; $display("FAIL b2b_int_after_push got %b exp 1", int_tx_done); end
      bus_write(4'h0, 32'h3C);
      for (int j = 0; j < 40; j++) begin
         e = (j < 20) ? frame_bit(8'hA5, j / 2) : frame_bit(8'h3C, (j - 20) / 2);
         checks++;
         if (txd !== e) begin errors++; $display("FAIL b2b_seq cycle %0d got %b exp %b", j, txd, e); end
         checks++;
         if (int_tx_done !== 1'b0) begin errors++; $display("FAIL b2b_int_busy cycle %0d got %b exp 0", j, int_tx_done); end
         @(posedge clk); #1;
      end
      checks++;
      if (int_tx_done !== 1'b0) begin errors++; $display("FAIL b2b_int_early got %b exp 0", int_tx_done); end
      @(posedge clk); #1;
      checks++;
      if (int_tx_done !== 1'b1) begin errors++; $display("FAIL b2b_int_rise got %b exp 1", int_tx_done); end
      bus_write(4'h3, 32'h0);
   endtask

   task automatic test_divisor;
      logic [31:0] rd;
      logic        e;
      bus_write(4'h2, 32'd0);
      bus_read(4'h2, rd);
      checks++;
      if (rd !== 32'd2) begin errors++; $display("FAIL div_clamp0 got %0d exp 2", rd); end
      bus_write(4'h2, 32'd1);
      bus_read(4'h2, rd);
      checks++;
      if (rd !== 32'd2) begin errors++; $display("FAIL div_clamp1 got %0d exp 2", rd); end
      bus_write(4'h0, 32'h96);
      bus_write(4'h0, 32'h0F);
      for (int j = 0; j < 100; j++) begin
         e = (j < 20) ? frame_bit(8'h96, j / 2) : frame_bit(8'h0F, (j - 20) / 8);
         checks++;
         if (txd !== e) begin errors++; $display("FAIL div_iso_seq cycle %0d got %b exp %b", j, txd, e); end
         if (j == 0) begin wea = 1'b1; addra = 4'h2; dina = 32'd8; end
         if (j == 1) begin wea = 1'b0; addra = 4'h0; dina = 32'h0; end
         @(posedge clk); #1;
      end
      bus_read(4'h2, rd);
      checks++;
      if (rd !== 32'd8) begin errors++; $display("FAIL div_readback got %0d exp 8", rd); end
   endtask

   task automatic test_reset_mid_frame;
      logic [31:0] rd;
      int lows;
      bus_write(4'h2, 32'd4);
      bus_write(4'h0, 32'h00);
      bus_write(4'h0, 32'h11);
      bus_write(4'h0, 32'h22);
      idle_cycles(16);
      checks++;
      if (txd !== 1'b0) begin errors++; $display("FAIL rmf_in_d3 got %b exp 0", txd); end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (txd !== 1'b1) begin errors++; $display("FAIL rmf_txd got %b exp 1", txd); end
      rst = 1'b1;
      checks++;
      if (douta !== 32'h0 || int_tx_done !== 1'b0) begin
         errors++; $display("FAIL rmf_outputs got %h/%b exp 0/0", douta, int_tx_done);
      end
      bus_read(4'h1, rd);
      checks++;
      if (rd !== 32'h20) begin errors++; $display("FAIL rmf_status got %h exp 20", rd); end
      bus_read(4'h2, rd);
      checks++;
      if (rd !== 32'd434) begin errors++; $display("FAIL rmf_divisor got %0d exp 434", rd); end
      lows = 0;
      for (int j = 0; j < 60; j++) begin
         @(posedge clk); #1;
         if (txd !== 1'b1) lows++;
      end
      checks++;
      if (lows != 0) begin errors++; $display("FAIL rmf_quiet got %0d low cycles exp 0", lows); end
   endtask

   task automatic test_unmapped;
      logic [31:0] rd;
      bus_read(4'h2, rd);
      bus_read(4'h7, rd);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL unmapped_read got %h exp 0", rd); end
      bus_write(4'hF, 32'hFFFF_FFFF);
      bus_read(4'h2, rd);
      checks++;
      if (rd !== 32'd434) begin errors++; $display("FAIL unmapped_divisor got %0d exp 434", rd); end
      bus_read(4'h3, rd);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL unmapped_intctrl got %h exp 0", rd); end
      bus_read(4'h1, rd);
      checks++;
      if (rd !== 32'h20) begin errors++; $display("FAIL unmapped_status got %h exp 20", rd); end
      checks++;
      if (txd !== 1'b1) begin errors++; $display("FAIL unmapped_txd got %b exp 1", txd); end
   endtask

   initial begin
      test_reset;
      test_single_byte;
      test_fill_overflow;
      test_back_to_back;
      test_divisor;
      test_reset_mid_frame;
      test_unmapped;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
